// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM single-port memory arbiter with req/ack sequencing
//
// Shares one single-port memory between instruction fetch and load/store.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   im_req/im_addr/flush     fetch request (level) and branch/jump squash
//   im_valid/im_rdata        one-cycle fetch completion pulse and instruction
//   dm_req/dm_we/dm_wstrb/
//   dm_addr/dm_wdata         data request (level), store enable, byte enables
//   dm_valid/dm_rdata        one-cycle data completion pulse and load data
//   mem_req/mem_we/mem_wstrb/
//   mem_addr/mem_wdata       registered memory request, held until mem_ack
//   mem_ack/mem_rdata        memory completion pulse and read data
//   stall_if/stall_mem       per-stage stalls to the hazard logic
//   err                      sticky mem_ack timeout flag
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                im_req,
  input  logic [ADDR_W-1:0]   im_addr,
  input  logic                flush,
  output logic                im_valid,
  output logic [DATA_W-1:0]   im_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                err
);

  // Wide enough to hold TIMEOUT+1 so the saturating increment never wraps.
  localparam int               CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_DM_BUSY = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_dm;  // last grant went to data; fetch wins the next tie
  logic             r_drop;     // in-flight fetch was squashed, discard its response
  logic [CNT_W-1:0] r_cnt;

  logic w_if_elig;
  logic w_grant_dm;
  logic w_grant_if;

  // A flushed fetch is not eligible, so flush in IDLE simply blocks the grant.
  assign w_if_elig  = im_req && !flush;
  assign w_grant_dm = dm_req && (!w_if_elig || !r_last_dm);
  assign w_grant_if = w_if_elig && !w_grant_dm;

  assign stall_if  = im_req && !im_valid;
  assign stall_mem = dm_req && !dm_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_last_dm <= 1'b0;
      r_drop    <= 1'b0;
      r_cnt     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      im_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      im_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      im_valid <= 1'b0;
      dm_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_state   <= S_DM_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_wstrb <= dm_we ? dm_wstrb : '0;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            r_last_dm <= 1'b1;
            r_cnt     <= '0;
          end else if (w_grant_if) begin
            r_state   <= S_IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= im_addr;
            mem_wdata <= '0;
            r_last_dm <= 1'b0;
            r_cnt     <= '0;
          end
        end

        S_IF_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
            // A flush landing on the ack cycle squashes just like an earlier one.
            if (!(r_drop || flush)) begin
              im_valid <= 1'b1;
              im_rdata <= mem_rdata;
            end
          end else if (flush) begin
            // The memory access is never aborted; only its response is dropped.
            r_drop <= 1'b1;
          end
        end

        S_DM_BUSY: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            r_state  <= S_IDLE;
            dm_valid <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // Timeout only flags the condition; the access keeps waiting for mem_ack.
      if (r_state != S_IDLE && !mem_ack) begin
        if (r_cnt != TO_C) r_cnt <= r_cnt + 1'b1;
        if (TIMEOUT != 0 && (r_cnt + 1'b1) >= TO_C) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        im_req, flush, dm_req, dm_we;
  logic [31:0] im_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_wstrb;
  logic        im_valid, dm_valid, mem_req, mem_we, stall_if, stall_mem, err;
  logic [31:0] im_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        ack_rsp, ack_stray = 1'b0;
  logic        mem_ack;

  assign mem_ack = ack_rsp | ack_stray;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .flush(flush),
    .im_valid(im_valid), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Stimulus queues (driver side) and scoreboard queues (monitor side)
  logic [31:0] im_q[$];
  req_t        dm_q[$];
  req_t        exp_req[$];
  logic [31:0] exp_im[$];
  logic [31:0] exp_dm[$];

  int          ack_lat = 1;
  logic        rsp_en = 1'b1;
  int          redir_seq = 0;
  logic [31:0] redir_addr = 32'h0;
  logic        chk_gap = 1'b0;
  int          n_im_v = 0;
  int          n_dm_v = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Fetch requester: level request held until im_valid; redirect pulses flush.
  initial begin : im_drv
    int redir_done;
    redir_done = 0;
    im_req = 1'b0; im_addr = 32'h0; flush = 1'b0;
    forever begin
      @(posedge clk); #1;
      flush = 1'b0;
      if (!rst) im_req = 1'b0;
      else begin
        if (im_req && im_valid) im_req = 1'b0;
        if (redir_seq != redir_done) begin
          flush = 1'b1;
          im_addr = redir_addr;
          redir_done = redir_seq;
        end
        if (!im_req && im_q.size() > 0) begin
          im_addr = im_q.pop_front();
          im_req = 1'b1;
        end
      end
    end
  end

  // Data requester: level request held until dm_valid.
  initial begin : dm_drv
    req_t r;
    dm_req = 1'b0; dm_we = 1'b0; dm_wstrb = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst) dm_req = 1'b0;
      else begin
        if (dm_req && dm_valid) dm_req = 1'b0;
        if (!dm_req && dm_q.size() > 0) begin
          r = dm_q.pop_front();
          dm_we = r.we; dm_wstrb = r.wstrb; dm_addr = r.addr; dm_wdata = r.wdata;
          dm_req = 1'b1;
        end
      end
    end
  end

  // Memory model: acks in the ack_lat-th cycle of mem_req.
  initial begin : responder
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] cur;
    int          wcnt;
    mem_m[32'h0000_0100] = 32'h0050_0093;
    mem_m[32'h0000_0104] = 32'hAAAA_5555;
    mem_m[32'h0000_0200] = 32'h1234_5678;
    mem_m[32'h0000_0300] = 32'h0000_0013;
    mem_m[32'h0000_2000] = 32'h1111_2222;
    mem_m[32'h0000_2004] = 32'h3333_4444;
    mem_m[32'h0000_2008] = 32'h0102_0304;
    ack_rsp = 1'b0; mem_rdata = 32'h0; wcnt = 0;
    forever begin
      @(posedge clk); #1;
      ack_rsp = 1'b0;
      if (rst && mem_req && rsp_en) begin
        wcnt++;
        if (wcnt >= ack_lat) begin
          ack_rsp = 1'b1;
          wcnt = 0;
          cur = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_m[mem_addr] = cur;
            mem_rdata = 32'h5A5A_5A5A;
          end else begin
            mem_rdata = cur;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: checks each memory request and each valid pulse against the scoreboard.
  initial begin : monitor
    req_t        cur;
    logic [31:0] e;
    logic        prev_req, have_fall;
    int          low_run, last_ack_cyc;
    cur = '0; prev_req = 1'b0; have_fall = 1'b0; low_run = 0; last_ack_cyc = -10;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0;
        have_fall = 1'b0;
        continue;
      end
      if (!chk_gap) have_fall = 1'b0;
      if (mem_req && !prev_req) begin
        if (chk_gap && have_fall) chk("idle_gap", 32'(low_run), 32'd1);
        if (exp_req.size() == 0) fail_now("unexpected_mem_req");
        else begin
          cur = exp_req.pop_front();
          chk("req_addr", mem_addr, cur.addr);
          chk("req_we", 32'(mem_we), 32'(cur.we));
          chk("req_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
          if (cur.we) chk("req_wdata", mem_wdata, cur.wdata);
        end
      end
      if (mem_req && mem_ack) begin
        chk("hold_addr", mem_addr, cur.addr);
        chk("hold_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
        if (cur.we) chk("hold_wdata", mem_wdata, cur.wdata);
        last_ack_cyc = cyc;
      end
      if (!mem_req) begin
        if (prev_req) begin
          low_run = 1;
          have_fall = 1'b1;
        end else low_run++;
      end
      prev_req = mem_req;

      if (im_valid) begin
        n_im_v++;
        chk("im_latency", 32'(cyc), 32'(last_ack_cyc + 1));
        if (exp_im.size() == 0) fail_now("unexpected_im_valid");
        else begin
          e = exp_im.pop_front();
          chk("im_rdata", im_rdata, e);
        end
      end
      if (dm_valid) begin
        n_dm_v++;
        chk("dm_latency", 32'(cyc), 32'(last_ack_cyc + 1));
        if (exp_dm.size() == 0) fail_now("unexpected_dm_valid");
        else begin
          e = exp_dm.pop_front();
          chk("dm_rdata", dm_rdata, e);
        end
      end
    end
  end

  task automatic wait_mem_req(input string nm);
    int k;
    k = 0;
    while (!mem_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!mem_req) fail_now(nm);
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (k < 200 && (im_q.size() + dm_q.size() + exp_req.size() + exp_im.size()
                       + exp_dm.size() != 0 || im_req || dm_req || mem_req)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) fail_now(nm);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic req_t mk(input logic we, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we = we; r.wstrb = s; r.addr = a; r.wdata = d;
    return r;
  endfunction

  initial begin : main
    int v0;
    int k;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_valids", {30'd0, im_valid, dm_valid}, 32'd0);
    chk("rst_im_rdata", im_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1. Fetch only, ack in 2nd cycle of mem_req
    ack_lat = 2;
    v0 = n_im_v;
    exp_req.push_back(mk(1'b0, 4'h0, 32'h100, 32'h0));
    exp_im.push_back(32'h0050_0093);
    im_q.push_back(32'h100);
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (im_valid) begin
        chk("t1_stall_if_done", 32'(stall_if), 32'd0);
        break;
      end else if (im_req) chk("t1_stall_if_wait", 32'(stall_if), 32'd1);
    end
    if (k >= 30) fail_now("t1_no_im_valid");
    wait_drain("t1_drain");
    chk("t1_one_pulse", 32'(n_im_v - v0), 32'd1);

    // 2. Simultaneous requests from reset: data, fetch, data
    do_reset();
    ack_lat = 1;
    chk_gap = 1'b1;
    exp_req.push_back(mk(1'b0, 4'h0, 32'h2000, 32'h0));
    exp_req.push_back(mk(1'b0, 4'h0, 32'h300, 32'h0));
    exp_req.push_back(mk(1'b0, 4'h0, 32'h2004, 32'h0));
    exp_dm.push_back(32'h1111_2222);
    exp_dm.push_back(32'h3333_4444);
    exp_im.push_back(32'h0000_0013);
    dm_q.push_back(mk(1'b0, 4'h0, 32'h2000, 32'h0));
    dm_q.push_back(mk(1'b0, 4'h0, 32'h2004, 32'h0));
    im_q.push_back(32'h300);
    wait_drain("t2_drain");
    chk_gap = 1'b0;

    // 3. Store with partial strobes, then load it back (load strobes masked)
    v0 = n_dm_v;
    exp_req.push_back(mk(1'b1, 4'b0011, 32'h2008, 32'hDEAD_BEEF));
    exp_req.push_back(mk(1'b0, 4'h0, 32'h2008, 32'h0));
    exp_dm.push_back(32'h3333_4444);
    exp_dm.push_back(32'h0102_BEEF);
    dm_q.push_back(mk(1'b1, 4'b0011, 32'h2008, 32'hDEAD_BEEF));
    dm_q.push_back(mk(1'b0, 4'hF, 32'h2008, 32'hCAFE_F00D));
    wait_drain("t3_drain");
    chk("t3_dm_pulses", 32'(n_dm_v - v0), 32'd2);

    // 4. Flush during fetch: response dropped, redirected fetch completes
    ack_lat = 3;
    v0 = n_im_v;
    exp_req.push_back(mk(1'b0, 4'h0, 32'h104, 32'h0));
    exp_req.push_back(mk(1'b0, 4'h0, 32'h200, 32'h0));
    exp_im.push_back(32'h1234_5678);
    im_q.push_back(32'h104);
    wait_mem_req("t4_no_req");
    redir_addr = 32'h200;
    redir_seq++;
    @(negedge clk);
    chk("t4_flush_seen", 32'(flush), 32'd1);
    chk("t4_req_held", 32'(mem_req), 32'd1);
    chk("t4_req_addr_held", mem_addr, 32'h104);
    wait_drain("t4_drain");
    chk("t4_im_pulses", 32'(n_im_v - v0), 32'd1);

    // 5. Timeout: ack withheld, err after 4 busy cycles, sticky after ack
    ack_lat = 1;
    rsp_en = 1'b0;
    exp_req.push_back(mk(1'b0, 4'h0, 32'h2000, 32'h0));
    exp_dm.push_back(32'h1111_2222);
    dm_q.push_back(mk(1'b0, 4'h0, 32'h2000, 32'h0));
    wait_mem_req("t5_no_req");
    chk("t5_stall_mem", 32'(stall_mem), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t5_err_busy%0d", i), 32'(err), 32'd0);
      @(negedge clk);
    end
    chk("t5_err_set", 32'(err), 32'd1);
    rsp_en = 1'b1;
    wait_drain("t5_drain");
    chk("t5_err_sticky", 32'(err), 32'd1);

    // 6. Reset mid data transaction, stray ack afterwards
    rsp_en = 1'b0;
    exp_req.push_back(mk(1'b0, 4'h0, 32'h2004, 32'h0));
    dm_q.push_back(mk(1'b0, 4'h0, 32'h2004, 32'h0));
    wait_mem_req("t6_no_req");
    v0 = n_dm_v;
    #2 rst = 1'b0;
    #1;
    chk("t6_async_mem_req", 32'(mem_req), 32'd0);
    chk("t6_async_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 ack_stray = 1'b1;
    @(posedge clk); #1 ack_stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_dm_valid", 32'(n_dm_v - v0), 32'd0);
    chk("t6_idle_after", 32'(mem_req), 32'd0);
    rsp_en = 1'b1;

    chk("sb_empty", 32'(exp_req.size() + exp_im.size() + exp_dm.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d)", n_pass, n_chk);
    $fatal(1);
  end

endmodule
